// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bus between EX control and the multiply/divide unit.
// The unit sits on the slave side; EX control and hazard logic use master.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             StartIn;
  logic [2:0]       OpIn;
  logic [WIDTH-1:0] OperandAIn;
  logic [WIDTH-1:0] OperandBIn;
  logic             BusyOut;
  logic             DoneOut;
  logic             DivByZeroOut;
  logic [WIDTH-1:0] HIOut;
  logic [WIDTH-1:0] LOOut;

  modport master (
    output StartIn, OpIn, OperandAIn, OperandBIn,
    input  BusyOut, DoneOut, DivByZeroOut, HIOut, LOOut
  );

  modport slave (
    input  StartIn, OpIn, OperandAIn, OperandBIn,
    output BusyOut, DoneOut, DivByZeroOut, HIOut, LOOut
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO, one result bit per cycle.
//
// state | meaning
// IDLE  | waiting for StartIn; MTHI/MTLO and divide-by-zero complete here
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// FIX   | sign correction and HI/LO write-back
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             Reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpMadd  = 3'b110;
  localparam logic [2:0] OpMsub  = 3'b111;

  logic [1:0]         state;
  logic [CntW-1:0]    count;
  logic [2:0]         opReg;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   operandMag;
  logic               resNeg;
  logic               remNeg;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               doneReg;
  logic               dbzReg;

  logic               isSignedOp;
  logic               isMulOp;
  logic               isDivOp;
  logic               divisorZero;
  logic               startIter;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               signA;
  logic               signB;

  always_comb begin
    isSignedOp  = (bus.OpIn == OpMult) || (bus.OpIn == OpDiv) ||
                  (bus.OpIn == OpMadd) || (bus.OpIn == OpMsub);
    isMulOp     = (bus.OpIn == OpMult) || (bus.OpIn == OpMultu) ||
                  (bus.OpIn == OpMadd) || (bus.OpIn == OpMsub);
    isDivOp     = (bus.OpIn == OpDiv) || (bus.OpIn == OpDivu);
    divisorZero = (bus.OperandBIn == '0);
    startIter   = bus.StartIn && (state == StIdle) &&
                  (isMulOp || (isDivOp && !divisorZero));
    signA       = isSignedOp && bus.OperandAIn[WIDTH-1];
    signB       = isSignedOp && bus.OperandBIn[WIDTH-1];
    // Two's-complement negation of the most negative value yields its own
    // bit pattern, which is exactly the unsigned magnitude we want.
    magA        = signA ? -bus.OperandAIn : bus.OperandAIn;
    magB        = signB ? -bus.OperandBIn : bus.OperandBIn;
  end

  assign bus.BusyOut      = (state != StIdle) || startIter;
  assign bus.DoneOut      = doneReg;
  assign bus.DivByZeroOut = dbzReg;
  assign bus.HIOut        = hiReg;
  assign bus.LOOut        = loReg;

  // Multiply step: work holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;

  always_comb begin
    mulSum  = {1'b0, work[2*WIDTH-1:WIDTH]} +
              (work[0] ? {1'b0, operandMag} : {(WIDTH+1){1'b0}});
    mulNext = {mulSum, work[WIDTH-1:1]};
  end

  // Divide step: work holds {partial remainder, dividend/quotient bits}.
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] divNext;

  always_comb begin
    divTrial = work[2*WIDTH-1:WIDTH-1] - {1'b0, operandMag};
    if (divTrial[WIDTH])
      divNext = {work[2*WIDTH-2:0], 1'b0};
    else
      divNext = {divTrial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] signedProd;
  logic [2*WIDTH-1:0] hiLo;
  logic [2*WIDTH-1:0] accSum;
  logic [2*WIDTH-1:0] accDiff;
  logic [WIDTH-1:0]   fixQuot;
  logic [WIDTH-1:0]   fixRem;

  always_comb begin
    signedProd = resNeg ? -work : work;
    hiLo       = {hiReg, loReg};
    accSum     = hiLo + signedProd;
    accDiff    = hiLo - signedProd;
    fixQuot    = resNeg ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    fixRem     = remNeg ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= StIdle;
      count      <= '0;
      opReg      <= '0;
      work       <= '0;
      operandMag <= '0;
      resNeg     <= 1'b0;
      remNeg     <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
      dbzReg     <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      case (state)
        StIdle: begin
          if (bus.StartIn) begin
            opReg <= bus.OpIn;
            count <= '0;
            if (isMulOp) begin
              work       <= {{WIDTH{1'b0}}, magB};
              operandMag <= magA;
              resNeg     <= signA ^ signB;
              remNeg     <= 1'b0;
              state      <= StMul;
            end else if (isDivOp) begin
              if (divisorZero) begin
                doneReg <= 1'b1;
                dbzReg  <= 1'b1;
              end else begin
                work       <= {{WIDTH{1'b0}}, magA};
                operandMag <= magB;
                resNeg     <= signA ^ signB;
                remNeg     <= signA;
                state      <= StDiv;
              end
            end else if (bus.OpIn == OpMthi) begin
              hiReg   <= bus.OperandAIn;
              doneReg <= 1'b1;
            end else begin
              loReg   <= bus.OperandAIn;
              doneReg <= 1'b1;
            end
          end
        end
        StMul: begin
          work <= mulNext;
          if (count == LastCount) begin
            count <= '0;
            state <= StFix;
          end else begin
            count <= count + 1'b1;
          end
        end
        StDiv: begin
          work <= divNext;
          if (count == LastCount) begin
            count <= '0;
            state <= StFix;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          case (opReg)
            OpMult, OpMultu: {hiReg, loReg} <= signedProd;
            OpMadd:          {hiReg, loReg} <= accSum;
            OpMsub:          {hiReg, loReg} <= accDiff;
            OpDiv, OpDivu: begin
              loReg <= fixQuot;
              hiReg <= fixRem;
            end
            default: ;
          endcase
          doneReg <= 1'b1;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule
